eth_stats_log_receiver: RTL and testbench
=========================================

// Module: eth_stats_log_receiver
// PURPOSE
//  Consumer end of the stats collector M_AXIS_LOG stream. Accepts fixed-length log records,
//  buffers them in an internal FIFO and forwards only complete, well-formed records on an AXIS master.
//  Never back-pressures the collector: records that do not fit are dropped whole and counted.
//  Sits between eth_stats_collector instances and the log DMA/merge path, in the clk domain.
// PARAMETERS
//  C_AXIS_LOG_WIDTH  64  data width of input and output streams
//  C_RECORD_BEATS    4   beats per record; tlast must be on beat C_RECORD_BEATS-1; legal range 2..C_FIFO_DEPTH
//  C_FIFO_DEPTH      16  FIFO entries; power of two, >= C_RECORD_BEATS
// PORTS
//  clk                    in   1                  single clock for all logic
//  rst_n                  in   1                  asynchronous active-low reset
//  enable                 in   1                  1 = accept new records
//  s_axis_log_tdata       in   C_AXIS_LOG_WIDTH   log record beat
//  s_axis_log_tlast       in   1                  last beat of record
//  s_axis_log_tvalid      in   1                  beat valid
//  s_axis_log_tready      out  1                  ready; 1 at all times out of reset
//  m_axis_tdata           out  C_AXIS_LOG_WIDTH   forwarded beat
//  m_axis_tlast           out  1                  regenerated, on every C_RECORD_BEATS-th output beat
//  m_axis_tvalid          out  1                  forwarded beat valid
//  m_axis_tready          in   1                  downstream ready
//  fifo_level             out  $clog2(C_FIFO_DEPTH)+1  committed entries not yet read
//  records_ok             out  32                 records committed to FIFO
//  records_dropped        out  32                 records discarded for lack of space
//  records_bad            out  32                 malformed records discarded
// BEHAVIOUR
//  Reset: all outputs 0 (incl. s_axis_log_tready); tready registered, goes 1 on first clk after rst_n rises.
//  Beat accepted when s_axis_log_tvalid & s_axis_log_tready. Pointers: wr_ptr (tentative), commit_ptr,
//  rd_ptr, each $clog2(C_FIFO_DEPTH)+1 bits, wrapping; free = C_FIFO_DEPTH - (wr_ptr - rd_ptr).
//  Input FSM:
//   IDLE: first beat: if !enable -> discard, no count (DISCARD if !tlast). Else if free < C_RECORD_BEATS ->
//         records_dropped++, DISCARD if !tlast. Else write beat, beat_cnt=1, RECV. tlast on first beat
//         -> records_bad++, rollback, stay IDLE.
//   RECV: write each beat, beat_cnt++. tlast with beat_cnt == C_RECORD_BEATS-1 -> commit_ptr<=wr_ptr+1,
//         records_ok++, IDLE. tlast early -> wr_ptr<=commit_ptr, records_bad++, IDLE. No tlast on
//         beat C_RECORD_BEATS-1 -> wr_ptr<=commit_ptr, records_bad++, DISCARD.
//   DISCARD: sink beats without writing until tlast accepted -> IDLE.
//  enable falling mid-record: record in RECV completes normally; enable only sampled in IDLE.
//  Output: registered skid-free stage; m_axis_tvalid asserts when rd_ptr != commit_ptr; holds tdata/tlast
//   stable while tvalid & !tready. Latency: record completing (tlast accepted) in cycle M with empty FIFO
//   and idle output -> m_axis_tvalid=1 in cycle M+2. Full throughput: one beat/cycle with tready=1.
//  Simultaneous read and write in one cycle permitted; free uses current rd_ptr (read freed space seen next cycle).
//  Full FIFO: exactly C_FIFO_DEPTH committed beats accepted; rollback never disturbs rd_ptr/commit_ptr.
//  Counters saturate at 32'hFFFFFFFF. fifo_level = commit_ptr - rd_ptr.
// CONFIGURATION
//  ESC_LOG_RX_COUNTERS_EN defined: records_ok/dropped/bad counters implemented as above.
//  Not defined: counter logic removed; the three ports tied to 32'd0; all other behaviour identical.
// TESTING
//  1. Reset, 4-beat record D0..D3 tlast on D3, tready=1 -> m_axis beats D0..D3 starting 2 cycles after D3,
//     tlast on D3; records_ok=1.
//  2. m_axis_tready=0, send 5 records (depth 16) -> records 1-4 stored, 5th dropped; records_dropped=1,
//     fifo_level=16; release tready -> exactly 16 beats, 4 tlasts.
//  3. 3-beat record with tlast on beat 2 then good record -> records_bad=1, only good record output.
//  4. 6-beat record without tlast until beat 5 -> records_bad=1, no output, next record accepted normally.
//  5. enable=0 in IDLE, send 2 records -> no output, all counters 0; enable dropped mid-record -> record output.
//  6. Assert rst_n=0 mid-record and mid-output -> all outputs 0 immediately; after release, new record passes intact.

Source files
------------

// File: rtl/eth_stats_log_receiver_if.sv
// Purpose : AXI-stream style beat bundle (tdata/tlast/tvalid/tready) shared by the log receiver's input and output.
// Latency : none, wires only.
// Backpressure: master drives tdata/tlast/tvalid, slave drives tready.
// Ports   : tdata [W-1:0], tlast, tvalid, tready; modports master and slave.
interface eth_stats_log_receiver_if #(
  parameter int W = 64
);
  logic [W-1:0] tdata;
  logic         tlast;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/eth_stats_log_receiver.sv
// Purpose : receives fixed-length log records, stores whole well-formed records in a FIFO and forwards them.
// Latency : record whose tlast is accepted in cycle M appears on m_axis (tvalid=1) in cycle M+2.
// Backpressure: never back-pressures the input (tready=1 out of reset); records that do not fit are dropped whole.
// Ports   : clk, rst_n (async active-low), enable, s_axis_log (slave), m_axis (master),
//           fifo_level, records_ok, records_dropped, records_bad.
// Build   : define ESC_LOG_RX_COUNTERS_EN to implement the three record counters; otherwise they read 0.
module eth_stats_log_receiver #(
  parameter int C_AXIS_LOG_WIDTH = 64,
  parameter int C_RECORD_BEATS   = 4,
  parameter int C_FIFO_DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  eth_stats_log_receiver_if.slave       s_axis_log,
  eth_stats_log_receiver_if.master      m_axis,
  output logic [$clog2(C_FIFO_DEPTH):0] fifo_level,
  output logic [31:0]                   records_ok,
  output logic [31:0]                   records_dropped,
  output logic [31:0]                   records_bad
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(C_RECORD_BEATS + 1);
  localparam logic [PW-1:0] DEPTH_P   = PW'(C_FIFO_DEPTH);
  localparam logic [PW-1:0] REC_P     = PW'(C_RECORD_BEATS);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(C_RECORD_BEATS - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DISCARD} state_t;

  state_t                      state;
  logic [C_AXIS_LOG_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr;      // tentative, runs ahead of commit_ptr inside a record
  logic [PW-1:0]               commit_ptr;  // end of the last complete record
  logic [PW-1:0]               rd_ptr;      // entry currently presented (or next to present) on m_axis
  logic [BW-1:0]               beat_cnt;
  logic                        s_rdy_q;

  logic [PW-1:0] free_cnt;
  logic          beat_acc;
  logic          has_room;
  logic          idle_take;
  logic          rec_end_ok;
  logic          rec_bad;
  logic          mem_we;

  assign s_axis_log.tready = s_rdy_q;
  assign beat_acc  = s_axis_log.tvalid & s_rdy_q;
  // Space is judged against the current rd_ptr; a read in this cycle frees space only from next cycle.
  assign free_cnt  = DEPTH_P - (wr_ptr - rd_ptr);
  assign has_room  = (free_cnt >= REC_P);
  assign idle_take = beat_acc & (state == ST_IDLE) & enable & has_room;
  assign rec_end_ok = beat_acc & (state == ST_RECV) & s_axis_log.tlast & (beat_cnt == LAST_BEAT);
  // Malformed: tlast before the final beat, or the final beat arriving without tlast.
  assign rec_bad   = beat_acc & (state == ST_RECV) & (s_axis_log.tlast ^ (beat_cnt == LAST_BEAT));
  // Beats of a record that may still be rolled back are written anyway: the room check at
  // the first beat guarantees these slots lie outside the committed region.
  assign mem_we    = (idle_take & ~s_axis_log.tlast) | (beat_acc & (state == ST_RECV));

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr[AW-1:0]] <= s_axis_log.tdata;
    end
  end

  // Input record FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      beat_cnt   <= '0;
      s_rdy_q    <= 1'b0;
    end else begin
      s_rdy_q <= 1'b1;
      if (beat_acc) begin
        unique case (state)
          ST_IDLE: begin
            // A single-beat record is malformed: nothing is written, so no rollback is needed.
            if (idle_take && !s_axis_log.tlast) begin
              wr_ptr   <= wr_ptr + PTR_ONE;
              beat_cnt <= BEAT_ONE;
              state    <= ST_RECV;
            end else if (!idle_take && !s_axis_log.tlast) begin
              state <= ST_DISCARD;
            end
          end
          ST_RECV: begin
            if (rec_end_ok) begin
              wr_ptr     <= wr_ptr + PTR_ONE;
              commit_ptr <= wr_ptr + PTR_ONE;
              state      <= ST_IDLE;
            end else if (rec_bad) begin
              wr_ptr <= commit_ptr;
              state  <= s_axis_log.tlast ? ST_IDLE : ST_DISCARD;
            end else begin
              wr_ptr   <= wr_ptr + PTR_ONE;
              beat_cnt <= beat_cnt + BEAT_ONE;
            end
          end
          ST_DISCARD: begin
            if (s_axis_log.tlast) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Output register. The presented entry stays in the FIFO until it is handshaken, so
  // fifo_level includes it; on a handshake the following entry is loaded in the same edge.
  logic [C_AXIS_LOG_WIDTH-1:0] m_dat_q;
  logic                        m_last_q;
  logic                        m_vld_q;
  logic [BW-1:0]               rd_pos;      // position within the record of the entry at rd_ptr
  logic [BW-1:0]               rd_pos_nxt;
  logic [PW-1:0]               rd_nxt;
  logic                        out_fire;

  assign rd_nxt     = rd_ptr + PTR_ONE;
  assign rd_pos_nxt = (rd_pos == LAST_BEAT) ? '0 : rd_pos + BEAT_ONE;
  assign out_fire   = m_vld_q & m_axis.tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      rd_pos   <= '0;
      m_dat_q  <= '0;
      m_last_q <= 1'b0;
      m_vld_q  <= 1'b0;
    end else if (out_fire) begin
      rd_ptr <= rd_nxt;
      rd_pos <= rd_pos_nxt;
      if (rd_nxt != commit_ptr) begin
        m_dat_q  <= mem[rd_nxt[AW-1:0]];
        m_last_q <= (rd_pos_nxt == LAST_BEAT);
      end else begin
        m_vld_q <= 1'b0;
      end
    end else if (!m_vld_q && (rd_ptr != commit_ptr)) begin
      m_vld_q  <= 1'b1;
      m_dat_q  <= mem[rd_ptr[AW-1:0]];
      m_last_q <= (rd_pos == LAST_BEAT);
    end
  end

  assign m_axis.tdata  = m_dat_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tvalid = m_vld_q;
  assign fifo_level    = commit_ptr - rd_ptr;

`ifdef ESC_LOG_RX_COUNTERS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        idle_full;
  logic        idle_bad;
  logic [31:0] ok_q;
  logic [31:0] drop_q;
  logic [31:0] bad_q;

  assign idle_full = beat_acc & (state == ST_IDLE) & enable & ~has_room;
  assign idle_bad  = idle_take & s_axis_log.tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q   <= '0;
      drop_q <= '0;
      bad_q  <= '0;
    end else begin
      if (rec_end_ok)         ok_q   <= sat_inc(ok_q);
      if (idle_full)          drop_q <= sat_inc(drop_q);
      if (idle_bad | rec_bad) bad_q  <= sat_inc(bad_q);
    end
  end

  assign records_ok      = ok_q;
  assign records_dropped = drop_q;
  assign records_bad     = bad_q;
`else
  assign records_ok      = 32'd0;
  assign records_dropped = 32'd0;
  assign records_bad     = 32'd0;
`endif

endmodule

// File: tb/tb_eth_stats_log_receiver.sv
// Purpose : self-checking bench for eth_stats_log_receiver with a scoreboard and a record-level reference model.
// Latency : checks the two-cycle record-to-output latency and beat-by-beat output order.
// Backpressure: drives m_axis tready held low, high or random.
`timescale 1ns/1ps
module tb_eth_stats_log_receiver;
  localparam int W     = 64;
  localparam int RB    = 4;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [31:0] records_ok, records_dropped, records_bad;

  always #5 clk = ~clk;

  eth_stats_log_receiver_if #(.W(W)) s_if ();
  eth_stats_log_receiver_if #(.W(W)) m_if ();

  eth_stats_log_receiver #(
    .C_AXIS_LOG_WIDTH(W),
    .C_RECORD_BEATS  (RB),
    .C_FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .s_axis_log     (s_if),
    .m_axis         (m_if),
    .fifo_level     (fifo_level),
    .records_ok     (records_ok),
    .records_dropped(records_dropped),
    .records_bad    (records_bad)
  );

  // Reference model state: records are classified whole, from enable at the first beat,
  // the space left in the FIFO and the record length.
  beat_t exp_q[$];
  int    m_ok = 0, m_drop = 0, m_bad = 0;
  int    committed = 0;   // beats of accepted records since reset
  int    consumed  = 0;   // beats handed downstream since reset
  int    checks = 0, passes = 0;
  int    rdy_mode = 1;    // 0 hold low, 1 hold high, 2 random

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef ESC_LOG_RX_COUNTERS_EN
    return 32'(v);
`else
    return (v == -1) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_ok"},    records_ok,      exp_cnt(m_ok));
    chk({tag, "_drop"},  records_dropped, exp_cnt(m_drop));
    chk({tag, "_bad"},   records_bad,     exp_cnt(m_bad));
    chk({tag, "_level"}, 64'(fifo_level), 64'(committed - consumed));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge; the first beat is accepted on the next edge.
  task automatic send_record(input int nbeats, input bit en_first, input bit en_rest, input int max_gap);
    int free;
    bit take;
    beat_t b;
    logic [W-1:0] d;
    free = DEPTH - (committed - consumed);
    take = 1'b0;
    if (!en_first) take = 1'b0;
    else if (free < RB) m_drop++;
    else if (nbeats != RB) m_bad++;
    else begin
      take = 1'b1;
      m_ok++;
      committed += RB;
    end
    for (int i = 0; i < nbeats; i++) begin
      d = {$urandom, $urandom};
      enable = (i == 0) ? en_first : en_rest;
      s_if.tdata  = d;
      s_if.tlast  = (i == nbeats - 1);
      s_if.tvalid = 1'b1;
      if (take) begin
        b.d = d;
        b.l = (i == RB - 1);
        exp_q.push_back(b);
      end
      cycle();
      s_if.tvalid = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) cycle();
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && n < 3000) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() == 0 && !m_if.tvalid) passes++;
    else $display("FAIL %s_drain: %0d beats still expected, tvalid=%0b after %0d cycles",
                  tag, exp_q.size(), m_if.tvalid, n);
  endtask

  // Downstream ready driver.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b0;
        1:       m_if.tready = 1'b1;
        default: m_if.tready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && m_if.tvalid && m_if.tready) begin
      consumed++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_beat: got data %0h last %0b, none expected", m_if.tdata, m_if.tlast);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", m_if.tdata, e.d);
        chk("out_last", 64'(m_if.tlast), 64'(e.l));
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    repeat (3) cycle();

    // Reset state.
    chk("rst_tready", 64'(s_if.tready), 0);
    chk("rst_tvalid", 64'(m_if.tvalid), 0);
    chk("rst_tdata",  m_if.tdata, 0);
    chk("rst_tlast",  64'(m_if.tlast), 0);
    chk_counters("rst");
    rst_n = 1'b1;
    chk("tready_pre_clk", 64'(s_if.tready), 0);
    cycle();
    chk("tready_post_clk", 64'(s_if.tready), 1);
    enable = 1'b1;

    // 1: single good record, two-cycle latency.
    send_record(RB, 1, 1, 0);
    chk("lat_m1_tvalid", 64'(m_if.tvalid), 0);
    cycle();
    chk("lat_m2_tvalid", 64'(m_if.tvalid), 1);
    wait_drain("t1");
    chk_counters("t1");

    // 2: downstream stalled, five records into a 16-deep FIFO.
    rdy_mode = 0;
    m_if.tready = 1'b0;
    for (int r = 0; r < 5; r++) send_record(RB, 1, 1, 0);
    cycle();
    chk_counters("t2");
    chk("t2_level16", 64'(fifo_level), 16);
    c0 = consumed;
    rdy_mode = 1;
    m_if.tready = 1'b1;
    wait_drain("t2");
    chk("t2_beats", 64'(consumed - c0), 16);
    chk_counters("t2_end");

    // 3: short record then good record.
    send_record(3, 1, 1, 0);
    send_record(RB, 1, 1, 0);
    wait_drain("t3");
    chk_counters("t3");

    // 4: long record then good record.
    send_record(6, 1, 1, 1);
    send_record(RB, 1, 1, 1);
    wait_drain("t4");
    chk_counters("t4");

    // 5: enable low in IDLE, then enable dropped mid-record.
    send_record(RB, 0, 0, 0);
    send_record(RB, 0, 0, 0);
    repeat (4) cycle();
    chk("t5_no_out", 64'(m_if.tvalid), 0);
    send_record(RB, 1, 0, 0);
    send_record(RB, 0, 0, 0);
    enable = 1'b1;
    wait_drain("t5");
    chk_counters("t5");

    // 6: reset mid-record and mid-output.
    rdy_mode = 0;
    m_if.tready = 1'b0;
    send_record(RB, 1, 1, 0);
    repeat (2) cycle();
    s_if.tdata  = 64'hDEAD_BEEF_0000_0001;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    repeat (2) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("r6_tready", 64'(s_if.tready), 0);
    chk("r6_tvalid", 64'(m_if.tvalid), 0);
    chk("r6_tdata",  m_if.tdata, 0);
    chk("r6_level",  64'(fifo_level), 0);
    exp_q.delete();
    committed = 0;
    consumed  = 0;
    m_ok = 0;
    m_drop = 0;
    m_bad = 0;
    chk_counters("r6");
    s_if.tvalid = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    rdy_mode = 1;
    m_if.tready = 1'b1;
    cycle();
    send_record(RB, 1, 1, 0);
    wait_drain("t6");
    chk_counters("t6");

    // 7: randomized records with random downstream stalls.
    rdy_mode = 2;
    for (int r = 0; r < 60; r++) begin
      int nb;
      nb = ($urandom_range(0, 9) < 7) ? RB : int'($urandom_range(1, 7));
      send_record(nb, $urandom_range(0, 9) != 0, $urandom_range(0, 1), 2);
      repeat ($urandom_range(0, 2)) cycle();
    end
    rdy_mode = 1;
    wait_drain("t7");
    chk_counters("t7");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
